// File: rtl/zhouzhouthezhou_adder_if.sv
// rtl/zhouzhouthezhou_adder_if.sv - TinyTapeout-style user pin bundle for the accumulator adder
interface zhouzhouthezhou_adder_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    // Drives operands/opcode and observes results
    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    // The accumulator core
    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/zhouzhouthezhou_adder.sv
// rtl/zhouzhouthezhou_adder.sv - 8-bit accumulator adder/subtractor with C/V/Z/N flags
module zhouzhouthezhou_adder (
    input logic                  clk,
    input logic                  rst,
    zhouzhouthezhou_adder_if.slave bus
);
    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_ADC  = 3'b011,
        OP_SUB  = 3'b100,
        OP_SBB  = 3'b101,
        OP_CLR  = 3'b110,
        OP_CMP  = 3'b111
    } op_e;

    logic [7:0] acc_q, acc_d;
    logic       c_q, c_d;
    logic       v_q, v_d;
    logic       z_q, z_d;
    logic       n_q, n_d;

    op_e        op;
    logic [7:0] b;
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic       cin_add;
    logic       cin_sub;
    logic       v_add;
    logic       v_sub;
    logic       unused_uio;

    assign op         = op_e'(bus.uio_in[2:0]);
    assign b          = bus.ui_in;
    assign unused_uio = ^bus.uio_in[7:3];

    // Adder and subtractor share operands; the old carry feeds ADC/SBB only.
    // Bit 8 of the 9-bit difference is the borrow out, i.e. ACC < B + cin.
    always_comb begin
        cin_add = (op == OP_ADC) ? c_q : 1'b0;
        cin_sub = (op == OP_SBB) ? c_q : 1'b0;
        sum9    = {1'b0, acc_q} + {1'b0, b} + {8'd0, cin_add};
        diff9   = {1'b0, acc_q} - {1'b0, b} - {8'd0, cin_sub};
        v_add   = (acc_q[7] == b[7]) && (sum9[7] != acc_q[7]);
        v_sub   = (acc_q[7] != b[7]) && (diff9[7] != acc_q[7]);
    end

    // Next-state selection by opcode; unlisted paths hold every register
    always_comb begin
        acc_d = acc_q;
        c_d   = c_q;
        v_d   = v_q;
        z_d   = z_q;
        n_d   = n_q;
        case (op)
            OP_LOAD: begin
                acc_d = b;
                c_d   = 1'b0;
                v_d   = 1'b0;
                z_d   = (b == 8'd0);
                n_d   = b[7];
            end
            OP_ADD, OP_ADC: begin
                acc_d = sum9[7:0];
                c_d   = sum9[8];
                v_d   = v_add;
                z_d   = (sum9[7:0] == 8'd0);
                n_d   = sum9[7];
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                if (op != OP_CMP) begin
                    acc_d = diff9[7:0];
                end
                c_d = diff9[8];
                v_d = v_sub;
                z_d = (diff9[7:0] == 8'd0);
                n_d = diff9[7];
            end
            OP_CLR: begin
                acc_d = 8'd0;
                c_d   = 1'b0;
                v_d   = 1'b0;
                z_d   = 1'b1;
                n_d   = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // State registers: reset beats enable, enable gates every update
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 8'd0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            z_q   <= 1'b1;
            n_q   <= 1'b0;
        end else if (bus.ena) begin
            acc_q <= acc_d;
            c_q   <= c_d;
            v_q   <= v_d;
            z_q   <= z_d;
            n_q   <= n_d;
        end
    end

    assign bus.uo_out  = acc_q;
    assign bus.uio_out = {c_q, v_q, z_q, n_q, 4'b0000};
    assign bus.uio_oe  = 8'hF0;
endmodule

// File: tb/tb_zhouzhouthezhou_adder.sv
// tb/tb_zhouzhouthezhou_adder.sv - scoreboard bench for the accumulator adder
module tb_zhouzhouthezhou_adder;
    logic clk;
    logic rst;

    zhouzhouthezhou_adder_if bus ();

    zhouzhouthezhou_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];

    // Reference state, kept with plain integer arithmetic
    int   m_acc;
    logic m_c, m_v, m_z, m_n;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    task automatic step(input logic r, input logic e, input logic [2:0] op,
                        input logic [7:0] b, input string tag);
        logic [4:0]  junk;
        logic [15:0] got_exp;
        int          cin, s, ss, res;
        junk       = 5'($urandom);
        rst        = r;
        bus.ena    = e;
        bus.ui_in  = b;
        bus.uio_in = {junk, op};
        if (r) begin
            m_acc = 0; m_c = 0; m_v = 0; m_z = 1; m_n = 0;
        end else if (e) begin
            case (op)
                3'd1: begin
                    m_acc = int'(b); m_c = 0; m_v = 0;
                    m_z = (b == 8'd0); m_n = b[7];
                end
                3'd2, 3'd3: begin
                    cin = (op == 3'd3) ? int'(m_c) : 0;
                    s   = m_acc + int'(b) + cin;
                    ss  = sgn(m_acc) + sgn(int'(b)) + cin;
                    res = s % 256;
                    m_acc = res; m_c = (s > 255);
                    m_v = (ss > 127) || (ss < -128);
                    m_z = (res == 0); m_n = (res >= 128);
                end
                3'd4, 3'd5, 3'd7: begin
                    cin = (op == 3'd5) ? int'(m_c) : 0;
                    s   = m_acc - int'(b) - cin;
                    ss  = sgn(m_acc) - sgn(int'(b)) - cin;
                    res = (s + 512) % 256;
                    if (op != 3'd7) m_acc = res;
                    m_c = (s < 0);
                    m_v = (ss > 127) || (ss < -128);
                    m_z = (res == 0); m_n = (res >= 128);
                end
                3'd6: begin
                    m_acc = 0; m_c = 0; m_v = 0; m_z = 1; m_n = 0;
                end
                default: begin
                end
            endcase
        end
        exp_q.push_back({8'(m_acc), m_c, m_v, m_z, m_n, 4'b0000});
        @(posedge clk);
        @(negedge clk);
        got_exp = exp_q.pop_front();
        chk({tag, "_uo"}, {8'd0, bus.uo_out}, {8'd0, got_exp[15:8]});
        chk({tag, "_uio"}, {8'd0, bus.uio_out}, {8'd0, got_exp[7:0]});
        chk({tag, "_oe"}, {8'd0, bus.uio_oe}, 16'h00F0);
    endtask

    initial begin
        rst        = 1'b1;
        bus.ena    = 1'b0;
        bus.ui_in  = 8'd0;
        bus.uio_in = 8'd0;
        m_acc = 0; m_c = 0; m_v = 0; m_z = 1; m_n = 0;
        @(negedge clk);

        // Reset with random inputs
        step(1'b1, 1'($urandom), 3'($urandom), 8'($urandom), "rst0");
        step(1'b1, 1'($urandom), 3'($urandom), 8'($urandom), "rst1");
        chk("rst_uo_const", {8'd0, bus.uo_out}, 16'h0000);
        chk("rst_uio_const", {8'd0, bus.uio_out}, 16'h0020);

        // Signed overflow on ADD
        step(1'b0, 1'b1, 3'd1, 8'h7F, "load7f");
        step(1'b0, 1'b1, 3'd2, 8'h01, "add01");
        chk("ovf_uo_const", {8'd0, bus.uo_out}, 16'h0080);
        chk("ovf_uio_const", {8'd0, bus.uio_out}, 16'h0050);

        // Carry out then carry in
        step(1'b0, 1'b1, 3'd1, 8'hFF, "loadff");
        step(1'b0, 1'b1, 3'd2, 8'h01, "addwrap");
        chk("wrap_uo_const", {8'd0, bus.uo_out}, 16'h0000);
        chk("wrap_cz_const", {14'd0, bus.uio_out[7], bus.uio_out[5]}, 16'h0003);
        step(1'b0, 1'b1, 3'd3, 8'h00, "adc00");
        chk("adc_uo_const", {8'd0, bus.uo_out}, 16'h0001);
        chk("adc_cz_const", {14'd0, bus.uio_out[7], bus.uio_out[5]}, 16'h0000);

        // Borrow then borrow in
        step(1'b0, 1'b1, 3'd1, 8'h05, "load05");
        step(1'b0, 1'b1, 3'd4, 8'h06, "sub06");
        chk("sub_uo_const", {8'd0, bus.uo_out}, 16'h00FF);
        chk("sub_uio_const", {8'd0, bus.uio_out}, 16'h0090);
        step(1'b0, 1'b1, 3'd5, 8'h00, "sbb00");
        chk("sbb_uo_const", {8'd0, bus.uo_out}, 16'h00FE);
        chk("sbb_c_const", {15'd0, bus.uio_out[7]}, 16'h0000);

        // Compare leaves ACC alone
        step(1'b0, 1'b1, 3'd1, 8'h10, "load10");
        step(1'b0, 1'b1, 3'd7, 8'h10, "cmpeq");
        chk("cmpeq_uo_const", {8'd0, bus.uo_out}, 16'h0010);
        chk("cmpeq_uio_const", {8'd0, bus.uio_out}, 16'h0020);
        step(1'b0, 1'b1, 3'd7, 8'h11, "cmplt");
        chk("cmplt_uo_const", {8'd0, bus.uo_out}, 16'h0010);
        chk("cmplt_cn_const", {14'd0, bus.uio_out[7], bus.uio_out[4]}, 16'h0003);

        // Enable low holds everything
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd2, 8'h33, "ena0");
        chk("ena0_uo_const", {8'd0, bus.uo_out}, 16'h0010);

        // Reset in the middle of an ADD stream
        step(1'b0, 1'b1, 3'd2, 8'h21, "stream0");
        step(1'b0, 1'b1, 3'd2, 8'h21, "stream1");
        step(1'b1, 1'b1, 3'd2, 8'h21, "streamrst");
        chk("streamrst_uo_const", {8'd0, bus.uo_out}, 16'h0000);
        step(1'b0, 1'b1, 3'd3, 8'h21, "postrst");
        chk("postrst_uo_const", {8'd0, bus.uo_out}, 16'h0021);

        // Clear from a dirty state
        step(1'b0, 1'b1, 3'd1, 8'hC3, "loadc3");
        step(1'b0, 1'b1, 3'd6, 8'h5A, "clr");
        chk("clr_uio_const", {8'd0, bus.uio_out}, 16'h0020);

        // Random back-to-back traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
                 3'($urandom), 8'($urandom), "rand");
        end

        chk("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
